// File: rtl/ctrl_pkg.sv
// Shared ISA, ALU and select encodings plus the control-unit state type for the accumulator computer.
package ctrl_pkg;

  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_JUMP  = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_JN    = 4'h9;
  localparam logic [3:0] OP_SHL   = 4'hA;
  localparam logic [3:0] OP_SHR   = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_SHL = 4'b0100;
  localparam logic [3:0] ALU_SHR = 4'b0101;
  localparam logic [3:0] ALU_AND = 4'b1000;
  localparam logic [3:0] ALU_OR  = 4'b1001;
  localparam logic [3:0] ALU_XOR = 4'b1010;

  localparam logic MAR_SEL_PC  = 1'b0;
  localparam logic MAR_SEL_IR  = 1'b1;
  localparam logic PC_SEL_INC  = 1'b0;
  localparam logic PC_SEL_IR   = 1'b1;
  localparam logic MBR_SEL_MEM = 1'b0;
  localparam logic MBR_SEL_ACC = 1'b1;
  localparam logic ACC_SEL_ALU = 1'b0;
  localparam logic ACC_SEL_MBR = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_F_ADDR  = 4'd1,
    ST_F_WAIT  = 4'd2,
    ST_F_LOAD  = 4'd3,
    ST_DECODE  = 4'd4,
    ST_E_ADDR  = 4'd5,
    ST_E_WAIT  = 4'd6,
    ST_E_MBR   = 4'd7,
    ST_E_ACC   = 4'd8,
    ST_S_ADDR  = 4'd9,
    ST_S_WRITE = 4'd10,
    ST_HALT    = 4'd11
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       mar_write;
    logic       mbr_write;
    logic       ir_write;
    logic       acc_write;
    logic       mem_write;
    logic       mar_sel;
    logic       pc_sel;
    logic       mbr_sel;
    logic       acc_sel;
    logic [3:0] alu_op;
    logic       halted;
    logic       instr_done;
  } ctrl_t;

  function automatic logic [3:0] alu_op_for(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_SHL:  return ALU_SHL;
      OP_SHR:  return ALU_SHR;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op == 4'hC) || (op == 4'hD) || (op == 4'hE);
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Moore output decode: registered state plus IR opcode and ACC flags to the control vector.
// Honours ILLEGAL_TRAP_EN: when defined, illegal opcodes do not retire in DECODE.
module ctrl_output_decode
  import ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [3:0] opcode,
  input  logic       acc_zero,
  input  logic       acc_neg,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_F_ADDR: begin
        ctrl.mar_write = 1'b1;
        ctrl.mar_sel   = MAR_SEL_PC;
      end
      ST_F_LOAD: begin
        ctrl.ir_write = 1'b1;
        ctrl.pc_write = 1'b1;
        ctrl.pc_sel   = PC_SEL_INC;
      end
      ST_DECODE: begin
        case (opcode)
          OP_JUMP: begin
            ctrl.pc_write   = 1'b1;
            ctrl.pc_sel     = PC_SEL_IR;
            ctrl.instr_done = 1'b1;
          end
          OP_JZ: begin
            ctrl.pc_write   = acc_zero;
            ctrl.pc_sel     = PC_SEL_IR;
            ctrl.instr_done = 1'b1;
          end
          OP_JN: begin
            ctrl.pc_write   = acc_neg;
            ctrl.pc_sel     = PC_SEL_IR;
            ctrl.instr_done = 1'b1;
          end
          default: begin
`ifdef ILLEGAL_TRAP_EN
            ctrl.instr_done = 1'b0;
`else
            // Illegal opcodes behave as a NOP that retires here.
            ctrl.instr_done = is_illegal(opcode);
`endif
          end
        endcase
      end
      ST_E_ADDR: begin
        ctrl.mar_write = 1'b1;
        ctrl.mar_sel   = MAR_SEL_IR;
      end
      ST_E_MBR: begin
        ctrl.mbr_write = 1'b1;
        ctrl.mbr_sel   = MBR_SEL_MEM;
      end
      ST_E_ACC: begin
        ctrl.acc_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        if (opcode == OP_LOAD) begin
          ctrl.acc_sel = ACC_SEL_MBR;
        end else begin
          ctrl.acc_sel = ACC_SEL_ALU;
          ctrl.alu_op  = alu_op_for(opcode);
        end
      end
      ST_S_ADDR: begin
        ctrl.mar_write = 1'b1;
        ctrl.mar_sel   = MAR_SEL_IR;
        ctrl.mbr_write = 1'b1;
        ctrl.mbr_sel   = MBR_SEL_ACC;
      end
      ST_S_WRITE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/fetch_execute_controller.sv
// Fetch/decode/execute sequencer for the accumulator datapath; owns only the state and wait counter.
// Optional ILLEGAL_TRAP_EN macro: illegal opcodes halt and raise a sticky illegal flag.
module fetch_execute_controller
  import ctrl_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter bit AUTO_RUN    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       acc_zero,
  input  logic       acc_neg,
  output logic       pc_write,
  output logic       mar_write,
  output logic       mbr_write,
  output logic       ir_write,
  output logic       acc_write,
  output logic       mem_write,
  output logic       mar_sel,
  output logic       pc_sel,
  output logic       mbr_sel,
  output logic       acc_sel,
  output logic [3:0] alu_op,
  output logic       halted,
  output logic       illegal,
  output logic       instr_done
);

  localparam logic [2:0] WAIT_LAST = 3'(MEM_LATENCY - 1);

  state_e     state_q, state_d;
  logic [2:0] wait_q, wait_d;
  ctrl_t      ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // The wait counter only runs inside the two wait states and is zero on entry to either.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    case (state_q)
      ST_IDLE:   if (run || AUTO_RUN) state_d = ST_F_ADDR;
      ST_F_ADDR: state_d = ST_F_WAIT;
      ST_F_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = ST_F_LOAD;
        else                     wait_d  = wait_q + 3'd1;
      end
      ST_F_LOAD: state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_LOAD, OP_ADD, OP_SUB,
          OP_AND, OP_OR, OP_XOR:     state_d = ST_E_ADDR;
          OP_STORE:                  state_d = ST_S_ADDR;
          OP_SHL, OP_SHR:            state_d = ST_E_ACC;
          OP_JUMP, OP_JZ, OP_JN:     state_d = ST_F_ADDR;
          OP_HALT:                   state_d = ST_HALT;
`ifdef ILLEGAL_TRAP_EN
          default:                   state_d = ST_HALT;
`else
          default:                   state_d = ST_F_ADDR;
`endif
        endcase
      end
      ST_E_ADDR: state_d = ST_E_WAIT;
      ST_E_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = ST_E_MBR;
        else                     wait_d  = wait_q + 3'd1;
      end
      ST_E_MBR:   state_d = ST_E_ACC;
      ST_E_ACC:   state_d = ST_F_ADDR;
      ST_S_ADDR:  state_d = ST_S_WRITE;
      ST_S_WRITE: state_d = ST_F_ADDR;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_IDLE;
    endcase
  end

  ctrl_output_decode u_decode (
    .state    (state_q),
    .opcode   (opcode),
    .acc_zero (acc_zero),
    .acc_neg  (acc_neg),
    .ctrl     (ctrl)
  );

  always_comb begin
    pc_write   = ctrl.pc_write;
    mar_write  = ctrl.mar_write;
    mbr_write  = ctrl.mbr_write;
    ir_write   = ctrl.ir_write;
    acc_write  = ctrl.acc_write;
    mem_write  = ctrl.mem_write;
    mar_sel    = ctrl.mar_sel;
    pc_sel     = ctrl.pc_sel;
    mbr_sel    = ctrl.mbr_sel;
    acc_sel    = ctrl.acc_sel;
    alu_op     = ctrl.alu_op;
    halted     = ctrl.halted;
    instr_done = ctrl.instr_done;
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky: only a reset clears it, matching the absorbing HALT it accompanies.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if (state_q == ST_DECODE && is_illegal(opcode)) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: doc/fetch_execute_controller.md
Name: fetch_execute_controller

Overview:
- Moore-style control unit that sequences the accumulator datapath (ACC, MAR, MBR, IR, PC registers, ALU, 16Ki x 16 main memory) through fetch, decode and execute.
- Owns no datapath storage except its state register and wait counter. It drives the register write enables, the datapath mux selects, the memory write strobe and the ALU opcode.
- Instantiated inside the top-level computer next to the Register, ALU and MainMemory instances.

Parameters:
- MEM_LATENCY, 1, cycles between MAR update and valid memory data_out; legal range 1..7.
- AUTO_RUN, 0, when 1 the controller leaves IDLE right after reset without waiting for run.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high; forces IDLE.
- run  in  1  start request; sampled only in IDLE.
- opcode  in  4  IR[15:12]; the IR holds the address field in [11:0].
- acc_zero  in  1  ACC == 0.
- acc_neg  in  1  ACC[15].
- pc_write, mar_write, mbr_write, ir_write, acc_write  out  1 each  register write enables.
- mem_write  out  1  memory write_enable; memory data_in = MBR, addr = MAR.
- mar_sel  out  1  0: PC, 1: IR[11:0] zero-extended.
- pc_sel  out  1  0: PC+1, 1: IR[11:0].
- mbr_sel  out  1  0: memory data_out, 1: ACC.
- acc_sel  out  1  0: ALU result, 1: MBR.
- alu_op  out  4  ALU opcode; operand1 = ACC, operand2 = MBR.
- halted  out  1  high in HALT.
- illegal  out  1  sticky illegal-opcode flag.
- instr_done  out  1  one-cycle pulse when an instruction retires.

Behaviour:
- Package ISA opcodes:
  - 0 LOAD, 1 STORE, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR.
  - 7 JUMP, 8 JZ, 9 JN, A SHL, B SHR, F HALT.
  - C, D, E are illegal.
- All outputs are decoded from the registered state only. Every write enable is 0 outside the states listed below.
- Reset: state IDLE, wait counter 0. All enables, selects and alu_op are 0; halted, illegal and instr_done are 0.
- reset wins over every other condition, including mid-instruction and in HALT. No partial memory write is issued after reset is sampled.
- IDLE: go to F_ADDR when run==1 or AUTO_RUN==1.
- F_ADDR: mar_write=1, mar_sel=0.
- F_WAIT: hold MEM_LATENCY cycles using the counter, then go to F_LOAD.
- F_LOAD: ir_write=1, pc_write=1, pc_sel=0. PC wrap from 0xFFFF is the datapath's concern.
- DECODE, by opcode:
  - LOAD/ADD/SUB/AND/OR/XOR → E_ADDR.
  - STORE → S_ADDR.
  - SHL/SHR → E_ACC.
  - JUMP: pc_write=1, pc_sel=1.
  - JZ/JN: pc_write = acc_zero / acc_neg, pc_sel=1.
  - Jumps retire here (instr_done=1) → F_ADDR.
  - HALT → HALT.
  - Illegal opcode: see Optional Feature.
- E_ADDR: mar_write=1, mar_sel=1. Then E_WAIT for MEM_LATENCY cycles, then E_MBR.
- E_MBR: mbr_write=1, mbr_sel=0.
- E_ACC: acc_write=1, instr_done=1 → F_ADDR.
  - LOAD: acc_sel=1.
  - Others: acc_sel=0 with alu_op ADD=0000, SUB=0001, AND=1000, OR=1001, XOR=1010, SHL=0100, SHR=0101.
- S_ADDR: mar_write=1, mar_sel=1, mbr_write=1, mbr_sel=1.
- S_WRITE: mem_write=1, instr_done=1 → F_ADDR.
- HALT: halted=1. Absorbing state; exited only by reset. run is ignored.
- alu_op is 0000 in every state where acc_write=0.
- Cycle counts with MEM_LATENCY=1:
  - memory ALU op or LOAD: 8 cycles.
  - STORE: 6 cycles.
  - jump (taken or not): 4 cycles.
  - shift: 5 cycles.
  - Each extra latency cycle adds 1 per memory read.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE goes to HALT, sets illegal=1 (sticky until reset), and does not assert instr_done.
- Undefined: an illegal opcode is a NOP; it retires in DECODE with instr_done=1 and goes to F_ADDR. illegal is tied 0.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode localparams;
  - ALU opcode localparams (shared with the ALU);
  - state enum typedef;
  - select encodings MAR_SEL_PC/IR, PC_SEL_INC/IR, MBR_SEL_MEM/ACC, ACC_SEL_ALU/MBR.
- One natural sub-module, ctrl_output_decode: pure combinational state+opcode → control vector. The FSM and wait counter stay in the top.

Test Plan:
- Program run:
  - Memory: M[0]=0x0010, M[1]=0x2011, M[2]=0x1012, M[3]=0xF000, M[0x10]=5, M[0x11]=7.
  - Pulse run → M[0x12]==12 and halted=1 after 8+8+6+4 cycles.
  - instr_done pulses exactly 3 times.
- Branches:
  - ACC=0, JZ 0x020 → PC=0x020.
  - ACC=0x8000, JZ 0x020 → PC=old+1 and JN 0x030 → PC=0x030; each takes 4 cycles.
- Latency: MEM_LATENCY=3, LOAD → F_WAIT and E_WAIT each last 3 cycles; instruction takes 12 cycles.
- Reset in S_ADDR → next cycle state IDLE and mem_write never asserted; memory unchanged.
- Shift: ACC=0x4001, SHL → acc_write with alu_op=0100 in cycle 5.
- Opcode 0xC:
  - With ILLEGAL_TRAP_EN → halted=1, illegal=1, no instr_done.
  - Without → instr_done=1 in DECODE, next fetch at PC+1.
